fnd_scan: RTL and testbench
===========================

FND_SCAN -- requirements
Module: fnd_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit stays lit; legal range 2..65535.
REQ-002 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port en  input  1  display enable; 0 turns every digit off.
REQ-006 Port load  input  1  single-cycle strobe that captures value_in.
REQ-007 Port value_in  input  16  four hex digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-008 Port number  output  4  hex nibble of the currently selected digit, fed to the downstream fnd decoder.
REQ-009 Port digit_sel  output  4  active-low one-hot common-anode digit select; bit i drives digit i.
REQ-010 Port frame_done  output  1  one-cycle pulse when digit 3's slot ends.

Function
REQ-011 The block SHALL hold a prescaler counting 0..SCAN_DIV-1 and assert an internal tick when the count is SCAN_DIV-1, then wrap to 0.
REQ-012 Digit index idx (2 bits) SHALL advance 0->1->2->3->0 on each tick.
REQ-013 When en=0 the prescaler and idx SHALL hold their values, and digit_sel SHALL be 4'b1111 from the next edge.
REQ-014 load=1 SHALL capture value_in into a shadow register and set a pending flag.
REQ-015 The display register SHALL update only at the frame boundary (tick with idx=3); if pending=1, it takes the shadow value and pending clears.
REQ-016 A second load before the boundary SHALL overwrite the shadow; only the last captured value is displayed.
REQ-017 A load coinciding with the frame boundary SHALL write value_in directly into the display register and leave pending=0.
REQ-018 number SHALL be registered: on each edge it takes the display-register nibble for the current idx, so outputs lag idx by exactly one cycle.
REQ-019 digit_sel SHALL be registered with the same latency and equal ~(1<<idx) when the digit is lit.
REQ-020 With LZ_BLANK=1, digit i (i>=1) SHALL be blanked (digit_sel=4'b1111, number still driven) when display nibbles i..3 are all zero.
REQ-021 Digit 0 SHALL never be blanked, so a display value of 0 shows a single "0".
REQ-022 frame_done SHALL pulse high for one cycle, on the cycle after a tick with idx=3, and only while en=1.
REQ-023 At most one digit_sel bit SHALL be low in any cycle.

Reset
REQ-024 On a clock edge with rst=1: prescaler=0, idx=0, shadow=0, display=0, pending=0, number=4'h0, digit_sel=4'b1111, frame_done=0.
REQ-025 rst SHALL take priority over load and en.
REQ-026 A load pending when rst asserts SHALL be discarded.
REQ-027 On the first edge after rst deasserts with en=1, digit_sel SHALL become 4'b1110 and number SHALL become 4'h0.

Structure
REQ-028 Package fnd_pkg SHALL hold constant FND_DIGITS=4, the default SCAN_DIV, and the one-hot/active-low select helper function.
REQ-029 Sub-module fnd_prescaler (parameter SCAN_DIV; ports clk, rst, en, tick) SHALL implement the prescaler and be instantiated once.
REQ-030 The number output SHALL connect directly to the existing fnd decoder without glue logic.

Verification (SCAN_DIV=4 unless stated)
REQ-031 Reset, then en=1 and load 16'h1234 -> after the first frame boundary, a full frame shows digit_sel 1110/1101/1011/0111 with number 4/3/2/1, each held 4 cycles.
REQ-032 LZ_BLANK=1, load 16'h0005 -> digit 0 shows 4'h5; digits 1-3 keep digit_sel=4'b1111 during their slots. Repeat with LZ_BLANK=0 -> the zeros are displayed.
REQ-033 Load 16'hAAAA then 16'hBEEF mid-frame -> the next frame shows BEEF only; AAAA never appears.
REQ-034 Load 16'hC0DE on the exact frame-boundary cycle -> the next frame shows C0DE and pending stays 0.
REQ-035 Deassert en for 10 cycles mid-frame -> digit_sel=4'b1111 and no frame_done; on re-enable, the scan resumes at the held idx with the remaining prescaler count.
REQ-036 Assert rst during digit 2 with a load pending -> all outputs take their reset values; after release, display=0 and digit 0 shows 4'h0.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package fnd_pkg;

  localparam int FND_DIGITS       = 4;
  localparam int SCAN_DIV_DEFAULT = 50000;

  // Active-low one-hot select for a common-anode digit: only bit idx is low.
  function automatic logic [FND_DIGITS-1:0] sel_onehot_n(input logic [1:0] idx);
    sel_onehot_n = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fnd_prescaler.sv
// Free-running divider that marks the end of each digit's lit slot.
module fnd_prescaler
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt;

  // The tick is only meaningful while scanning; a frozen counter never ticks.
  assign tick = en && (cnt == LAST);

  // Count 0..SCAN_DIV-1 while enabled, hold the count while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (en) begin
      if (cnt == LAST) cnt <= 16'd0;
      else             cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fnd_scan.sv
// Four-digit multiplexed hex display scanner with frame-synchronous update
// and optional leading-zero blanking.
module fnd_scan
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic [3:0]  number,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  logic        tick;
  logic        boundary;
  logic [1:0]  idx;
  logic [15:0] shadow;
  logic [15:0] display;
  logic        pending;
  logic [3:0]  num_p1;
  logic [3:0]  sel_p1;
  logic        fd_p1;

  // Nibble of the display register belonging to digit i.
  function automatic logic [3:0] nib_sel(input logic [15:0] disp, input logic [1:0] i);
    case (i)
      2'd0:    nib_sel = disp[3:0];
      2'd1:    nib_sel = disp[7:4];
      2'd2:    nib_sel = disp[11:8];
      default: nib_sel = disp[15:12];
    endcase
  endfunction

  // A digit is a leading zero when it and every more significant nibble are
  // zero; digit 0 is always shown so that a zero value still reads "0".
  function automatic logic lz_hide(input logic [15:0] disp, input logic [1:0] i);
    case (i)
      2'd1:    lz_hide = (disp[15:4]  == 12'h000);
      2'd2:    lz_hide = (disp[15:8]  == 8'h00);
      2'd3:    lz_hide = (disp[15:12] == 4'h0);
      default: lz_hide = 1'b0;
    endcase
  endfunction

  fnd_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // End of digit 3's slot: the only point where the shown value may change.
  assign boundary = tick && (idx == 2'd3);

  // Step through the digits once per slot; tick is already gated by en.
  always_ff @(posedge clk) begin
    if (rst)       idx <= 2'd0;
    else if (tick) idx <= idx + 2'd1;
  end

  // Capture loads into the shadow and publish them only between frames so a
  // frame never mixes digits of two different values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= 16'h0000;
      display <= 16'h0000;
      pending <= 1'b0;
    end else if (load && boundary) begin
      shadow  <= value_in;
      display <= value_in;
      pending <= 1'b0;
    end else begin
      if (boundary && pending) begin
        display <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end
    end
  end

  // Stage p1: registered digit outputs, one cycle behind idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_p1 <= 4'h0;
      sel_p1 <= 4'b1111;
      fd_p1  <= 1'b0;
    end else begin
      num_p1 <= nib_sel(display, idx);
      if (!en || ((LZ_BLANK != 0) && lz_hide(display, idx))) sel_p1 <= 4'b1111;
      else                                                  sel_p1 <= sel_onehot_n(idx);
      fd_p1  <= boundary;
    end
  end

  assign number     = num_p1;
  assign digit_sel  = sel_p1;
  assign frame_done = fd_p1;

endmodule

// File: tb/tb_fnd_scan.sv
// Scoreboard bench for fnd_scan: one instance with leading-zero blanking and
// one without, driven by the same stimulus and checked every cycle.
module tb_fnd_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  n1, s1, n0, s0;
  logic        f1, f0;

  always #5 clk = ~clk;

  fnd_scan #(.SCAN_DIV(DIV), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .value_in(value_in),
    .number(n1), .digit_sel(s1), .frame_done(f1)
  );

  fnd_scan #(.SCAN_DIV(DIV), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .value_in(value_in),
    .number(n0), .digit_sel(s0), .frame_done(f0)
  );

  typedef struct packed {
    logic [3:0] num;
    logic [3:0] sel1;
    logic [3:0] sel0;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  int tests  = 0;
  int errs   = 0;
  int seen_a = 0;

  // Reference state of the scanner.
  int          m_cnt;
  logic [1:0]  m_idx;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pend;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, predict the outputs of the coming edge, then compare.
  task automatic step(input logic r, input logic e, input logic l, input logic [15:0] v);
    exp_t        x;
    logic [15:0] sh;
    logic        hide;
    logic        tk;
    logic        bnd;
    rst = r; en = e; load = l; value_in = v;
    if (r) begin
      x = '{num: 4'h0, sel1: 4'hF, sel0: 4'hF, fd: 1'b0};
    end else begin
      sh     = m_disp >> (4 * m_idx);
      hide   = (m_idx != 2'd0) && (sh == 16'h0000);
      x.num  = sh[3:0];
      x.sel0 = e ? ~(4'b0001 << m_idx) : 4'hF;
      x.sel1 = (e && !hide) ? ~(4'b0001 << m_idx) : 4'hF;
      x.fd   = e && (m_cnt == DIV - 1) && (m_idx == 2'd3);
    end
    sb.push_back(x);

    if (r) begin
      m_cnt = 0; m_idx = 2'd0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
    end else begin
      tk  = e && (m_cnt == DIV - 1);
      bnd = tk && (m_idx == 2'd3);
      if (l && bnd) begin
        m_disp = v; m_shadow = v; m_pend = 1'b0;
      end else begin
        if (bnd && m_pend) begin
          m_disp = m_shadow; m_pend = 1'b0;
        end
        if (l) begin
          m_shadow = v; m_pend = 1'b1;
        end
      end
      if (tk) begin
        m_cnt = 0; m_idx = m_idx + 2'd1;
      end else if (e) begin
        m_cnt = m_cnt + 1;
      end
    end

    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("num_lz1", 16'(n1), 16'(x.num));
    chk("num_lz0", 16'(n0), 16'(x.num));
    chk("sel_lz1", 16'(s1), 16'(x.sel1));
    chk("sel_lz0", 16'(s0), 16'(x.sel0));
    chk("fd_lz1",  16'(f1), 16'(x.fd));
    chk("fd_lz0",  16'(f0), 16'(x.fd));
    chk("onehot",  16'($countones(~s1) <= 1), 16'd1);
    if (s1 != 4'hF && n1 == 4'hA) seen_a++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value_in = 16'h0000;
    m_cnt = 0; m_idx = 2'd0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;

    // Reset, with reset overriding a simultaneous load and enable.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF);

    // Plain scan of 1234 across more than two frames.
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    idle(40);

    // Leading zeros: blanked on dut1, shown on dut0.
    step(1'b0, 1'b1, 1'b1, 16'h0005);
    idle(36);

    // Two loads within one frame: only the second is ever shown.
    for (int i = 0; i < 20 && m_idx != 2'd1; i++) idle(1);
    step(1'b0, 1'b1, 1'b1, 16'hAAAA);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 16'hBEEF);
    idle(36);

    // Load landing exactly on the frame boundary.
    for (int i = 0; i < 40 && !((m_cnt == DIV - 1) && (m_idx == 2'd3)); i++) idle(1);
    step(1'b0, 1'b1, 1'b1, 16'hC0DE);
    chk("pend_c0de", 16'(dut1.pending), 16'd0);
    idle(20);

    // Disable mid-frame, then resume from the held position.
    for (int i = 0; i < 20 && m_idx != 2'd1; i++) idle(1);
    idle(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    idle(20);

    // Reset during digit 2 while a load is pending.
    for (int i = 0; i < 20 && m_idx != 2'd0; i++) idle(1);
    step(1'b0, 1'b1, 1'b1, 16'h9876);
    for (int i = 0; i < 20 && m_idx != 2'd2; i++) idle(1);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    idle(24);

    chk("no_aaaa", 16'(seen_a), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
